// File: rtl/pagerank_pkg.sv
// Shared types and helpers for the PageRank gather/apply stage.
// Fixed-point ranks and contributions are unsigned Q8.24.
package pagerank_pkg;

    typedef logic [31:0] fix_q8_24_t;

    localparam int Q_RANK_FRAC = 24;
    localparam int Q_DAMP_SHIFT = 16;

    typedef enum logic [1:0] {
        ACCUM,
        FINALIZE,
        DONE
    } gather_state_t;

    function automatic fix_q8_24_t sat_add32(
        input fix_q8_24_t a,
        input fix_q8_24_t b
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/gather_lane_select.sv
// Fixed-priority picker: lowest-index pending lane wins.
module gather_lane_select
    import pagerank_pkg::*;
#(
    parameter int NUM_LANES = 8
) (
    input  logic [NUM_LANES-1:0]         pending,
    output logic [$clog2(NUM_LANES)-1:0] sel,
    output logic                         any
);

    localparam int IDX_W = $clog2(NUM_LANES);

    always_comb begin
        sel = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

    assign any = |pending;

endmodule

// File: rtl/pagerank_gather.sv
// Gather/apply stage: serialises lane contributions into node
// accumulators, then applies damping to publish the rank vector.
module pagerank_gather
    import pagerank_pkg::*;
#(
    parameter int          NUM_HW_THREADS = 8,
    parameter int          NODES_IN_GRAPH = 32,
    parameter logic [15:0] DAMPING        = 16'hD99A,
    parameter logic [31:0] BASE_TERM      = 32'h0001_3333,
    parameter logic [31:0] INIT_RANK      = 32'h0008_0000
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_HW_THREADS-1:0] stream_valid,
    input  logic [31:0]               dest_update [NUM_HW_THREADS],
    input  logic [31:0]               contribution [NUM_HW_THREADS],
    input  logic                      dmp_complete,
    input  logic                      next_iteration,
    input  logic [31:0]               rank_rd_addr,
    output logic [31:0]               rank_rd_data,
    output logic                      stall_dmp,
    output logic                      gather_done,
    output logic                      dest_err
);

    localparam int LANE_W = $clog2(NUM_HW_THREADS);
    localparam int NODE_W = $clog2(NODES_IN_GRAPH);
    localparam logic [NODE_W-1:0] LAST_NODE =
        NODE_W'(NODES_IN_GRAPH - 1);
    localparam logic [31:0] NODE_LIMIT = 32'(NODES_IN_GRAPH);

    gather_state_t state;
    logic [NODE_W-1:0] node_cnt;

    logic [NUM_HW_THREADS-1:0] pending;
    logic [31:0] dest [NUM_HW_THREADS];
    fix_q8_24_t val [NUM_HW_THREADS];

    fix_q8_24_t acc [NODES_IN_GRAPH];
    fix_q8_24_t rank [NODES_IN_GRAPH];

    logic [LANE_W-1:0] sel;
    logic any_pending;
    logic captured;
    logic [31:0] sel_dest;
    fix_q8_24_t sel_val;
    logic sel_in_range;
    logic [NODE_W-1:0] sel_node;

    logic [47:0] prod;
    fix_q8_24_t scaled;
    fix_q8_24_t new_rank;

    gather_lane_select #(
        .NUM_LANES(NUM_HW_THREADS)
    ) u_select (
        .pending(pending),
        .sel    (sel),
        .any    (any_pending)
    );

    assign stall_dmp = any_pending || (state != ACCUM);
    assign captured = !stall_dmp && (|stream_valid);

    assign sel_dest = dest[sel];
    assign sel_val = val[sel];
    assign sel_in_range = sel_dest < NODE_LIMIT;
    assign sel_node = sel_dest[NODE_W-1:0];

    assign prod = 48'(acc[node_cnt]) * 48'(DAMPING);
    assign scaled = 32'(prod >> Q_DAMP_SHIFT);
    assign new_rank = sat_add32(BASE_TERM, scaled);

    always_comb begin
        rank_rd_data = '0;
        if (rank_rd_addr < NODE_LIMIT) begin
            rank_rd_data = rank[rank_rd_addr[NODE_W-1:0]];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ACCUM;
            node_cnt <= '0;
            gather_done <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (dmp_complete && !any_pending && !captured) begin
                        state <= FINALIZE;
                        node_cnt <= '0;
                    end
                end
                FINALIZE: begin
                    node_cnt <= node_cnt + 1'b1;
                    if (node_cnt == LAST_NODE) begin
                        state <= DONE;
                        gather_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (next_iteration) begin
                        state <= ACCUM;
                        node_cnt <= '0;
                        gather_done <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    // Capture only happens with the pending set empty, so it never
    // collides with a retire in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            for (int i = 0; i < NUM_HW_THREADS; i++) begin
                dest[i] <= '0;
                val[i] <= '0;
            end
        end else if (!stall_dmp) begin
            for (int i = 0; i < NUM_HW_THREADS; i++) begin
                if (stream_valid[i]) begin
                    pending[i] <= 1'b1;
                    dest[i] <= dest_update[i];
                    val[i] <= contribution[i];
                end
            end
        end else if (any_pending) begin
            pending[sel] <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dest_err <= 1'b0;
            for (int n = 0; n < NODES_IN_GRAPH; n++) begin
                acc[n] <= '0;
                rank[n] <= INIT_RANK;
            end
        end else begin
            if (state == ACCUM && any_pending) begin
                if (sel_in_range) begin
                    acc[sel_node] <= sat_add32(acc[sel_node], sel_val);
                end else begin
                    dest_err <= 1'b1;
                end
            end
            if (state == FINALIZE) begin
                acc[node_cnt] <= '0;
                rank[node_cnt] <= new_rank;
            end
        end
    end

endmodule

// File: tb/tb_pagerank_gather.sv
// Directed + randomized bench for pagerank_gather with an
// arithmetic reference model of accumulation and damping.
module tb_pagerank_gather;

    localparam int LANES = 8;
    localparam int NODES = 32;
    localparam logic [31:0] BASE = 32'h0001_3333;
    localparam logic [31:0] INIT = 32'h0008_0000;
    localparam longint unsigned DAMP = 64'hD99A;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [LANES-1:0] stream_valid;
    logic [31:0] dest_update [LANES];
    logic [31:0] contribution [LANES];
    logic dmp_complete;
    logic next_iteration;
    logic [31:0] rank_rd_addr;
    logic [31:0] rank_rd_data;
    logic stall_dmp;
    logic gather_done;
    logic dest_err;

    longint unsigned m_acc [NODES];
    logic [31:0] m_rank [NODES];
    logic m_err;

    logic [31:0] b_dest [LANES];
    logic [31:0] b_val [LANES];

    int n_total = 0;
    int n_pass = 0;

    pagerank_gather dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stream_valid  (stream_valid),
        .dest_update   (dest_update),
        .contribution  (contribution),
        .dmp_complete  (dmp_complete),
        .next_iteration(next_iteration),
        .rank_rd_addr  (rank_rd_addr),
        .rank_rd_data  (rank_rd_data),
        .stall_dmp     (stall_dmp),
        .gather_done   (gather_done),
        .dest_err      (dest_err)
    );

    always #5 clock = ~clock;

    task automatic check(
        input string tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] sat32(input longint unsigned x);
        return (x > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : x[31:0];
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NODES; n++) begin
            m_acc[n] = 0;
            m_rank[n] = INIT;
        end
        m_err = 1'b0;
    endtask

    task automatic model_finalize();
        longint unsigned r;
        for (int n = 0; n < NODES; n++) begin
            r = longint'(BASE) + ((m_acc[n] * DAMP) >> 16);
            m_rank[n] = sat32(r);
            m_acc[n] = 0;
        end
    endtask

    task automatic model_apply(input logic [LANES-1:0] mask);
        logic [31:0] d;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                d = b_dest[i];
                if (d < NODES) begin
                    m_acc[d[4:0]] = sat32(m_acc[d[4:0]] + b_val[i]);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_batch();
        for (int i = 0; i < LANES; i++) begin
            b_dest[i] = '0;
            b_val[i] = '0;
        end
    endtask

    task automatic read_rank(
        input logic [31:0] a,
        output logic [31:0] d
    );
        rank_rd_addr = a;
        #1;
        d = rank_rd_data;
    endtask

    task automatic drive(input logic [LANES-1:0] mask);
        int cnt;
        cnt = 0;
        while (stall_dmp && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        stream_valid = mask;
        dest_update = b_dest;
        contribution = b_val;
        model_apply(mask);
        @(negedge clock);
        stream_valid = '0;
    endtask

    task automatic send(input logic [LANES-1:0] mask);
        int cnt;
        drive(mask);
        cnt = 0;
        while (stall_dmp && cnt < 50) begin
            cnt++;
            @(negedge clock);
        end
        check("stall_cycles", 32'(cnt), 32'($countones(mask)));
    endtask

    task automatic check_ranks(input string tag);
        logic [31:0] d;
        for (int n = 0; n < NODES; n++) begin
            read_rank(32'(n), d);
            check(tag, d, m_rank[n]);
        end
        read_rank(32'(NODES), d);
        check("oob_addr", d, 32'h0);
    endtask

    task automatic finish_iter(input int exp_cycles);
        int cnt;
        cnt = 0;
        while (!gather_done && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        check("finalize_cycles", 32'(cnt), 32'(exp_cycles));
        dmp_complete = 1'b0;
        check("stall_in_done", 32'(stall_dmp), 32'h1);
        model_finalize();
        check_ranks("rank");
        check("dest_err", 32'(dest_err), 32'(m_err));
        next_iteration = 1'b1;
        @(negedge clock);
        next_iteration = 1'b0;
        check("done_drop", 32'(gather_done), 32'h0);
        check("stall_release", 32'(stall_dmp), 32'h0);
    endtask

    initial begin
        logic [31:0] d;
        stream_valid = '0;
        dmp_complete = 1'b0;
        next_iteration = 1'b0;
        rank_rd_addr = '0;
        clear_batch();
        dest_update = b_dest;
        contribution = b_val;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        check("rst_stall", 32'(stall_dmp), 32'h0);
        check("rst_done", 32'(gather_done), 32'h0);
        check("rst_err", 32'(dest_err), 32'h0);
        read_rank(32'd5, d);
        check("rst_rank5", d, 32'h0008_0000);

        clear_batch();
        b_dest[0] = 4;
        b_dest[3] = 4;
        b_val[0] = 32'h0010_0000;
        b_val[3] = 32'h0010_0000;
        send(8'b0000_1001);
        dmp_complete = 1'b1;
        finish_iter(33);
        read_rank(32'd4, d);
        check("rank4_const", d, 32'h001C_6673);
        read_rank(32'd0, d);
        check("rank0_const", d, 32'h0001_3333);

        clear_batch();
        b_dest[0] = 2;
        b_dest[1] = 2;
        b_val[0] = 32'hF000_0000;
        b_val[1] = 32'hF000_0000;
        send(8'b0000_0011);
        dmp_complete = 1'b1;
        finish_iter(33);
        read_rank(32'd2, d);
        check("rank2_sat", d, 32'hD99B_3332);

        clear_batch();
        b_dest[0] = 7;
        b_val[0] = 32'h0020_0000;
        b_dest[1] = 40;
        b_val[1] = 32'h0100_0000;
        b_dest[5] = 7;
        b_val[5] = 32'h0003_0000;
        send(8'b0010_0011);
        check("err_set", 32'(dest_err), 32'h1);
        dmp_complete = 1'b1;
        finish_iter(33);
        check("err_sticky", 32'(dest_err), 32'h1);

        clear_batch();
        b_dest[2] = 9;
        b_val[2] = 32'h0040_0000;
        b_dest[4] = 9;
        b_val[4] = 32'h0001_0000;
        b_dest[6] = 30;
        b_val[6] = 32'h0123_4567;
        drive(8'b0101_0100);
        dmp_complete = 1'b1;
        check("pend_stall", 32'(stall_dmp), 32'h1);
        finish_iter(36);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < LANES; i++) begin
                    b_dest[i] = $urandom_range(0, 35);
                    if ($urandom_range(0, 3) == 0) begin
                        b_val[i] = $urandom;
                    end else begin
                        b_val[i] = $urandom_range(0, 32'h00FF_FFFF);
                    end
                end
                send(8'($urandom_range(0, 255)));
            end
            dmp_complete = 1'b1;
            finish_iter(33);
        end

        clear_batch();
        b_dest[0] = 12;
        b_val[0] = 32'h0200_0000;
        b_dest[1] = 20;
        b_val[1] = 32'h0030_0000;
        send(8'b0000_0011);
        dmp_complete = 1'b1;
        repeat (11) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall_dmp), 32'h0);
        check("mid_rst_done", 32'(gather_done), 32'h0);
        check("mid_rst_err", 32'(dest_err), 32'h0);
        dmp_complete = 1'b0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        check_ranks("rank_after_rst");
        dmp_complete = 1'b1;
        finish_iter(33);
        read_rank(32'd12, d);
        check("acc_cleared", d, BASE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
